// File: rtl/rst_seq_gen.sv
// -----------------------------------------------------------------------------
// rst_seq_gen
//   Reset sequencer. Holds every reset channel asserted after the master reset,
//   then releases the channels one at a time in ascending index order, spaced
//   by a fixed gap. In the idle state a masked software request re-asserts the
//   selected channels and releases them again with the same hold/gap timing.
//
// Parameters
//   CHANNELS     number of reset channels (>= 1)
//   HOLD_CYCLES  cycles the affected channels stay asserted before the first
//                release (>= 1)
//   GAP_CYCLES   cycles between consecutive releases (>= 1)
//
// Ports
//   clk          single clock
//   srst         master reset, synchronous, active-high, overrides everything
//   req_rst      software re-reset request, one-cycle pulse, honoured only
//                while idle with a non-zero req_mask
//   req_mask     channels targeted by req_rst, sampled with req_rst
//   ch_srst      per-channel reset, active-high (registered)
//   ch_srstn     per-channel reset, active-low, always ~ch_srst
//   all_ready    high while idle with every channel released (registered)
//   dbg_state_o  current FSM state: 0 = ASSERT, 1 = RELEASE, 2 = DONE
//
// Handshake: req_rst/req_mask have no ready signal. A request is accepted
// only when it is sampled while all_ready is high; any other request is
// dropped without queuing, so software must wait for all_ready.
// -----------------------------------------------------------------------------
module rst_seq_gen #(
   parameter int CHANNELS    = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 4
) (
   input  logic                clk,
   input  logic                srst,
   input  logic                req_rst,
   input  logic [CHANNELS-1:0] req_mask,
   output logic [CHANNELS-1:0] ch_srst,
   output logic [CHANNELS-1:0] ch_srstn,
   output logic                all_ready,
   output logic [1:0]          dbg_state_o
);

   localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW      = $clog2(MAX_CYC) + 1;

   // The counter starts at 0 on the cycle a phase is entered, so a phase of
   // N cycles completes when the counter reads N-1.
   localparam logic [CW-1:0]       HOLD_TC = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0]       GAP_TC  = CW'(GAP_CYCLES - 1);
   localparam logic [CHANNELS-1:0] ONE     = CHANNELS'(1);

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_RELEASE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   state_t              state_q;
   logic [CW-1:0]       cnt_q;
   logic [CHANNELS-1:0] pend_q;
   logic [CHANNELS-1:0] ch_q;
   logic                ready_q;

   logic [CHANNELS-1:0] low_bit;
   logic [CHANNELS-1:0] pend_after;

   // Isolate the lowest set bit of pend (two's-complement trick).
   assign low_bit    = pend_q & (~pend_q + ONE);
   assign pend_after = pend_q & ~low_bit;

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q <= ST_ASSERT;
         cnt_q   <= '0;
         pend_q  <= '1;
         ch_q    <= '1;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               if (cnt_q == HOLD_TC) begin
                  ch_q   <= ch_q & ~low_bit;
                  pend_q <= pend_after;
                  cnt_q  <= '0;
                  if (pend_after == '0) begin
                     state_q <= ST_DONE;
                     ready_q <= 1'b1;
                  end else begin
                     state_q <= ST_RELEASE;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            ST_RELEASE: begin
               if (cnt_q == GAP_TC) begin
                  ch_q   <= ch_q & ~low_bit;
                  pend_q <= pend_after;
                  cnt_q  <= '0;
                  if (pend_after == '0) begin
                     state_q <= ST_DONE;
                     ready_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            ST_DONE: begin
               // Only masked channels are re-asserted; the rest keep running.
               if (req_rst && (req_mask != '0)) begin
                  ch_q    <= ch_q | req_mask;
                  pend_q  <= req_mask;
                  cnt_q   <= '0;
                  ready_q <= 1'b0;
                  state_q <= ST_ASSERT;
               end
            end

            default: begin
               state_q <= ST_ASSERT;
               cnt_q   <= '0;
               pend_q  <= '1;
               ch_q    <= '1;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign ch_srst     = ch_q;
   assign ch_srstn    = ~ch_q;
   assign all_ready   = ready_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_gen
//   Drives three sequencer instances (4/16/4, 1/1/1, 8/16/2) from shared
//   srst/req_rst/req_mask. A timeline model computes, for every sequence,
//   the edge on which each channel must release from the hold/gap formulas;
//   outputs are compared every cycle, plus fixed cycle numbers from the
//   power-up, re-reset, abort and collision scenarios.
// -----------------------------------------------------------------------------
module tb_rst_seq_gen;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       srst     = 1'b1;
   logic       req_rst  = 1'b0;
   logic [7:0] req_mask = 8'h00;

   logic [3:0] ch0, chn0;
   logic [0:0] ch1, chn1;
   logic [7:0] ch2, chn2;
   logic       rdy0, rdy1, rdy2;
   logic [1:0] dbg0, dbg1, dbg2;

   rst_seq_gen #(.CHANNELS(4), .HOLD_CYCLES(16), .GAP_CYCLES(4)) u_dut0 (
      .clk(clk), .srst(srst), .req_rst(req_rst), .req_mask(req_mask[3:0]),
      .ch_srst(ch0), .ch_srstn(chn0), .all_ready(rdy0), .dbg_state_o(dbg0));

   rst_seq_gen #(.CHANNELS(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) u_dut1 (
      .clk(clk), .srst(srst), .req_rst(req_rst), .req_mask(req_mask[0:0]),
      .ch_srst(ch1), .ch_srstn(chn1), .all_ready(rdy1), .dbg_state_o(dbg1));

   rst_seq_gen #(.CHANNELS(8), .HOLD_CYCLES(16), .GAP_CYCLES(2)) u_dut2 (
      .clk(clk), .srst(srst), .req_rst(req_rst), .req_mask(req_mask),
      .ch_srst(ch2), .ch_srstn(chn2), .all_ready(rdy2), .dbg_state_o(dbg2));

   // ---------------- reference model ----------------
   int P_C[3] = '{4, 1, 16 / 2};
   int P_H[3] = '{16, 1, 16};
   int P_G[3] = '{4, 1, 2};

   logic [7:0] m_ch[3];
   logic [7:0] m_pend[3];
   logic       m_busy[3];
   logic       m_ready[3];
   logic       m_sched[3];
   int         m_rel[3][8];

   // Output history, indexed by edge number (value sampled just after it).
   logic [7:0] h_ch[3][0:4095];
   logic       h_rdy[3][0:4095];

   int edge_n = -1;
   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_step(input int i, input int n);
      logic [7:0] am, m;
      int j;
      am = 8'((1 << P_C[i]) - 1);
      m  = req_mask & am;
      if (srst) begin
         m_ch[i] = am; m_pend[i] = 8'h00;
         m_busy[i] = 1'b1; m_ready[i] = 1'b0; m_sched[i] = 1'b1;
      end else begin
         if (m_sched[i]) begin
            // First edge with srst low: channel k releases H-1+k*G edges later.
            m_sched[i] = 1'b0;
            m_pend[i]  = am;
            for (int k = 0; k < P_C[i]; k++) m_rel[i][k] = n + P_H[i] - 1 + k * P_G[i];
         end else if (!m_busy[i] && req_rst && (m != 8'h00)) begin
            m_ch[i] = m_ch[i] | m; m_pend[i] = m;
            m_busy[i] = 1'b1; m_ready[i] = 1'b0;
            j = 0;
            for (int k = 0; k < 8; k++) begin
               if (m[k]) begin
                  m_rel[i][k] = n + P_H[i] + j * P_G[i];
                  j++;
               end
            end
         end
         if (m_busy[i]) begin
            for (int k = 0; k < 8; k++) begin
               if (m_pend[i][k] && (m_rel[i][k] == n)) begin
                  m_pend[i][k] = 1'b0;
                  m_ch[i][k]   = 1'b0;
               end
            end
            if (m_pend[i] == 8'h00) begin
               m_busy[i] = 1'b0; m_ready[i] = 1'b1;
            end
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic tick();
      logic [7:0] o_ch[3], o_chn[3], am;
      logic       o_rdy[3];
      @(posedge clk);
      edge_n++;
      for (int i = 0; i < 3; i++) model_step(i, edge_n);
      #1;
      o_ch[0] = {4'h0, ch0};  o_chn[0] = {4'h0, chn0};  o_rdy[0] = rdy0;
      o_ch[1] = {7'h00, ch1}; o_chn[1] = {7'h00, chn1}; o_rdy[1] = rdy1;
      o_ch[2] = ch2;          o_chn[2] = chn2;          o_rdy[2] = rdy2;
      for (int i = 0; i < 3; i++) begin
         am = 8'((1 << P_C[i]) - 1);
         chk($sformatf("ch_srst[%0d]@%0d", i, edge_n), 32'(o_ch[i]), 32'(m_ch[i]));
         chk($sformatf("ch_srstn[%0d]@%0d", i, edge_n), 32'(o_chn[i]), 32'(~m_ch[i] & am));
         chk($sformatf("all_ready[%0d]@%0d", i, edge_n), 32'(o_rdy[i]), 32'(m_ready[i]));
         if (edge_n < 4096) begin
            h_ch[i][edge_n]  = o_ch[i];
            h_rdy[i][edge_n] = o_rdy[i];
         end
      end
      chk($sformatf("dbg_idle[0]@%0d", edge_n), 32'(dbg0 == 2'd2), 32'(!m_busy[0]));
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) tick();
   endtask

   task automatic pulse_req(input logic [7:0] m);
      req_rst = 1'b1; req_mask = m;
      tick();
      req_rst = 1'b0; req_mask = 8'h00;
   endtask

   // Fixed cycle numbers of a full power-up sequence; e0 is the first edge
   // that samples srst low, so "cycle c" is the value just after edge e0+c-1.
   task automatic check_powerup(input int e0, input string nm);
      chk({nm, " c15 1111"}, 32'(h_ch[0][e0+14]), 32'h0f);
      chk({nm, " c16 1110"}, 32'(h_ch[0][e0+15]), 32'h0e);
      chk({nm, " c19 1110"}, 32'(h_ch[0][e0+18]), 32'h0e);
      chk({nm, " c20 1100"}, 32'(h_ch[0][e0+19]), 32'h0c);
      chk({nm, " c24 1000"}, 32'(h_ch[0][e0+23]), 32'h08);
      chk({nm, " c28 0000"}, 32'(h_ch[0][e0+27]), 32'h00);
      chk({nm, " c27 ready low"}, 32'(h_rdy[0][e0+26]), 32'h0);
      chk({nm, " c28 ready high"}, 32'(h_rdy[0][e0+27]), 32'h1);
      chk({nm, " ch1 c0 held"}, 32'(h_ch[1][e0-1]), 32'h1);
      chk({nm, " ch1 c1 released"}, 32'(h_ch[1][e0]), 32'h0);
      chk({nm, " ch1 c1 ready"}, 32'(h_rdy[1][e0]), 32'h1);
      chk({nm, " ch8 c29 bit7 held"}, 32'(h_ch[2][e0+28][7]), 32'h1);
      chk({nm, " ch8 c30 bit7 released"}, 32'(h_ch[2][e0+29][7]), 32'h0);
      chk({nm, " ch8 c30 ready"}, 32'(h_rdy[2][e0+29]), 32'h1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int e0, t;
      for (int i = 0; i < 3; i++) begin
         m_ch[i] = 8'h00; m_pend[i] = 8'h00;
         m_busy[i] = 1'b0; m_ready[i] = 1'b0; m_sched[i] = 1'b0;
      end

      // Power-up: srst for 5 cycles, then full release.
      srst = 1'b1;
      run(5);
      chk("reset ch_srst", 32'(ch0), 32'h0f);
      chk("reset ch_srstn", 32'(chn0), 32'h00);
      chk("reset all_ready", 32'(rdy0), 32'h0);
      srst = 1'b0;
      e0 = edge_n + 1;
      run(35);
      check_powerup(e0, "powerup");

      // Masked re-reset with mask 1010.
      t = edge_n + 1;
      pulse_req(8'hAA);
      run(30);
      chk("rereset T+1 1010", 32'(h_ch[0][t]), 32'h0a);
      chk("rereset T+1 ready low", 32'(h_rdy[0][t]), 32'h0);
      chk("rereset T+16 1010", 32'(h_ch[0][t+15]), 32'h0a);
      chk("rereset T+17 1000", 32'(h_ch[0][t+16]), 32'h08);
      chk("rereset T+20 1000", 32'(h_ch[0][t+19]), 32'h08);
      chk("rereset T+21 0000", 32'(h_ch[0][t+20]), 32'h00);
      chk("rereset T+20 ready low", 32'(h_rdy[0][t+19]), 32'h0);
      chk("rereset T+21 ready high", 32'(h_rdy[0][t+20]), 32'h1);

      // Zero-mask request while idle: nothing may change.
      pulse_req(8'h00);
      run(3);
      chk("zero mask ch", 32'(ch0), 32'h00);
      chk("zero mask ready", 32'(rdy0), 32'h1);

      // Power-up with an all-ones request sampled at cycle 18 (ignored).
      srst = 1'b1;
      run(2);
      srst = 1'b0;
      e0 = edge_n + 1;
      run(18);
      pulse_req(8'hFF);
      run(20);
      check_powerup(e0, "ignored req");

      // srst at cycle 21, after two channels have released.
      srst = 1'b1;
      run(2);
      srst = 1'b0;
      e0 = edge_n + 1;
      run(21);
      chk("abort before c21", 32'(ch0), 32'h0c);
      srst = 1'b1;
      tick();
      chk("abort all ones", 32'(ch0), 32'h0f);
      chk("abort ready low", 32'(rdy0), 32'h0);
      srst = 1'b0;
      e0 = edge_n + 1;
      run(35);
      check_powerup(e0, "abort restart");

      // srst and req_rst (mask 0001) in the same idle cycle.
      srst = 1'b1; req_rst = 1'b1; req_mask = 8'h01;
      tick();
      chk("collision all ones", 32'(ch0), 32'h0f);
      srst = 1'b0; req_rst = 1'b0; req_mask = 8'h00;
      e0 = edge_n + 1;
      run(35);
      check_powerup(e0, "collision");

      // Random traffic against the model.
      for (int c = 0; c < 300; c++) begin
         srst     = ($urandom_range(0, 59) == 0);
         req_rst  = ($urandom_range(0, 4) == 0);
         req_mask = 8'($urandom);
         tick();
      end
      srst = 1'b0; req_rst = 1'b0; req_mask = 8'h00;
      run(40);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
